// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Predicts the next fetch PC combinationally and learns from outcomes resolved in ID.
module branch_predictor #(
  parameter int         ENTRIES  = 16,
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_cond,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int TAG_BITS = 32 - IDX_BITS - 2;

  logic                entry_valid  [ENTRIES];
  logic [TAG_BITS-1:0] entry_tag    [ENTRIES];
  logic [31:0]         entry_target [ENTRIES];
  logic                entry_uncond [ENTRIES];
  logic [1:0]          entry_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic                fetch_hit;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic                unused_bits;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc[31:IDX_BITS+2];
  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_tag   = upd_pc[31:IDX_BITS+2];

  // Instruction addresses are word aligned, so the low two bits carry no information.
  assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign fetch_hit   = entry_valid[fetch_idx] && (entry_tag[fetch_idx] == fetch_tag);
  assign upd_hit     = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

  assign pred_taken  = fetch_hit && (entry_uncond[fetch_idx] || entry_ctr[fetch_idx][1]);
  assign pred_target = pred_taken ? entry_target[fetch_idx] : fetch_pc + 32'd4;

  assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  // Tags and targets are left unreset; a cleared valid bit makes them irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_valid[i] <= 1'b0;
        entry_ctr[i]   <= CTR_INIT;
      end
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd_valid) begin
      branch_count <= branch_count + 32'd1;
      if (mispredict) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
      if (upd_hit) begin
        if (upd_is_cond) begin
          if (upd_taken && entry_ctr[upd_idx] != 2'b11) begin
            entry_ctr[upd_idx] <= entry_ctr[upd_idx] + 2'd1;
          end else if (!upd_taken && entry_ctr[upd_idx] != 2'b00) begin
            entry_ctr[upd_idx] <= entry_ctr[upd_idx] - 2'd1;
          end
        end
        if (upd_taken) begin
          entry_target[upd_idx] <= upd_target;
        end
        entry_uncond[upd_idx] <= !upd_is_cond;
      end else if (upd_taken) begin
        entry_valid[upd_idx]  <= 1'b1;
        entry_tag[upd_idx]    <= upd_tag;
        entry_target[upd_idx] <= upd_target;
        entry_uncond[upd_idx] <= !upd_is_cond;
        entry_ctr[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor, checked against a
// behavioural table model that tracks counters as bounded integers.
module tb_branch_predictor;

  localparam int ENTRIES  = 16;
  localparam int IDX_BITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  bit          m_unc   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_bc;
  int unsigned m_mc;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES), .IDX_BITS(IDX_BITS), .CTR_INIT(2'b01)) dut (
    .clk(clk),
    .rst(rst),
    .fetch_pc(fetch_pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_is_cond(upd_is_cond),
    .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict(mispredict),
    .redirect_pc(redirect_pc),
    .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = m_index(pc);
    return m_valid[i] && (m_tag[i] == m_tagof(pc));
  endfunction

  task automatic m_predict(input logic [31:0] pc, output bit taken, output logic [31:0] target);
    int i = m_index(pc);
    taken  = m_hit(pc) && (m_unc[i] || m_ctr[i] >= 2);
    target = taken ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic drive(input bit r, input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                       input bit ucond, input bit utaken, input logic [31:0] utgt,
                       input bit upt, input logic [31:0] uptgt);
    rst             = r;
    fetch_pc        = fpc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_is_cond     = ucond;
    upd_taken       = utaken;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
  endtask

  // Checks every output against the model mid-cycle, then clocks and advances the model.
  task automatic applyStimulus();
    bit          exp_pt;
    logic [31:0] exp_tgt;
    bit          exp_mp;
    int          j;
    @(negedge clk);
    m_predict(fetch_pc, exp_pt, exp_tgt);
    exp_mp = upd_valid && ((upd_taken != upd_pred_taken) ||
                           (upd_taken && upd_target != upd_pred_target));
    checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, exp_pt});
    checkOutput("pred_target", pred_target, exp_tgt);
    checkOutput("mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
    checkOutput("redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
    checkOutput("branch_count", branch_count, m_bc);
    checkOutput("mispredict_count", mispredict_count, m_mc);
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (upd_valid) begin
      m_bc++;
      if (exp_mp) m_mc++;
      j = m_index(upd_pc);
      if (m_hit(upd_pc)) begin
        if (upd_is_cond) m_ctr[j] = upd_taken ? ((m_ctr[j] + 1 > 3) ? 3 : m_ctr[j] + 1)
                                              : ((m_ctr[j] - 1 < 0) ? 0 : m_ctr[j] - 1);
        if (upd_taken) m_tgt[j] = upd_target;
        m_unc[j] = !upd_is_cond;
      end else if (upd_taken) begin
        m_valid[j] = 1'b1;
        m_tag[j]   = m_tagof(upd_pc);
        m_tgt[j]   = upd_target;
        m_unc[j]   = !upd_is_cond;
        m_ctr[j]   = 2;
      end
    end
    #1;
  endtask

  initial begin
    bit          rp;
    logic [31:0] rt, pc, tgt;
    bit          cond, taken;

    drive(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    m_reset();

    drive(0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("rst_pred_target", pred_target, 32'h14);
    checkOutput("rst_branch_count", branch_count, 32'd0);
    checkOutput("rst_mispredict_count", mispredict_count, 32'd0);
    applyStimulus();

    drive(0, 32'h10, 1, 32'h10, 1, 1, 32'h40, 0, 32'h14);
    #2;
    checkOutput("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("alloc_redirect", redirect_pc, 32'h40);
    checkOutput("hazard_pre_update", {31'd0, pred_taken}, 32'd0);
    applyStimulus();

    drive(0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    checkOutput("alloc_pred_target", pred_target, 32'h40);
    checkOutput("alloc_branch_count", branch_count, 32'd1);
    checkOutput("alloc_mispredict_count", mispredict_count, 32'd1);
    applyStimulus();

    drive(0, 32'h10, 1, 32'h10, 1, 0, 32'h40, 1, 32'h40);
    #2;
    checkOutput("nt1_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("nt1_redirect", redirect_pc, 32'h14);
    applyStimulus();
    drive(0, 32'h10, 1, 32'h10, 1, 0, 32'h40, 0, 32'h14);
    #2;
    checkOutput("nt2_mispredict", {31'd0, mispredict}, 32'd0);
    applyStimulus();
    drive(0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("nt_pred_taken", {31'd0, pred_taken}, 32'd0);
    applyStimulus();
    drive(0, 32'h10, 1, 32'h10, 1, 0, 32'h40, 0, 32'h14);
    applyStimulus();
    drive(0, 32'h10, 1, 32'h10, 1, 1, 32'h40, 0, 32'h14);
    applyStimulus();
    drive(0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("sat_low_pred_taken", {31'd0, pred_taken}, 32'd0);
    applyStimulus();

    drive(0, 32'h50, 1, 32'h50, 0, 1, 32'h200, 0, 32'h54);
    #2;
    checkOutput("alias_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("alias_pred_target", pred_target, 32'h54);
    applyStimulus();
    drive(0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("evicted_pred_target", pred_target, 32'h14);
    applyStimulus();
    drive(0, 32'h50, 1, 32'h50, 0, 1, 32'h300, 1, 32'h200);
    #2;
    checkOutput("jr_pred_target", pred_target, 32'h200);
    checkOutput("jr_mispredict", {31'd0, mispredict}, 32'd1);
    checkOutput("jr_redirect", redirect_pc, 32'h300);
    applyStimulus();
    drive(0, 32'h50, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("jr_new_target", pred_target, 32'h300);
    applyStimulus();

    drive(1, 32'h50, 1, 32'h10, 1, 1, 32'h80, 0, 32'h14);
    applyStimulus();
    drive(0, 32'h50, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("midrst_pred_target", pred_target, 32'h54);
    checkOutput("midrst_branch_count", branch_count, 32'd0);
    checkOutput("midrst_mispredict_count", mispredict_count, 32'd0);
    applyStimulus();
    drive(0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("midrst_upd_ignored", {31'd0, pred_taken}, 32'd0);
    applyStimulus();

    for (int n = 0; n < 400; n++) begin
      pc    = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      cond  = ($urandom_range(0, 3) != 0);
      taken = cond ? 1'($urandom_range(0, 1)) : 1'b1;
      tgt   = 32'($urandom_range(0, 255)) << 2;
      m_predict(pc, rp, rt);
      if ($urandom_range(0, 3) == 0) begin
        rp = 1'($urandom_range(0, 1));
        rt = 32'($urandom_range(0, 255)) << 2;
      end
      drive($urandom_range(0, 63) == 0,
            (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2),
            $urandom_range(0, 3) != 0, pc, cond, taken, tgt, rp, rt);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Branch target buffer (BTB) with 2-bit saturating counters, placed upstream of the pipelined CPU's fetch path.
- Each cycle it takes the fetch PC and produces a predicted next PC in the same cycle; the CPU drives this into its PC register.
- The ID stage resolves branches, jumps and jr, then reports the outcome back to this block, which updates its tables.
- The block also flags mispredictions, supplies the corrected fetch PC, and keeps branch and mispredict statistics counters.

Parameters:
- ENTRIES, 16: number of direct-mapped BTB entries; must be a power of 2, minimum 2.
- IDX_BITS, 4: log2(ENTRIES).
- CTR_INIT, 2'b01: counter value loaded at reset (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- fetch_pc  in  32  PC currently being fetched.
- pred_taken  out  1  prediction for fetch_pc: redirect.
- pred_target  out  32  predicted next PC.
- upd_valid  in  1  a control-flow instruction resolved in ID this cycle; the CPU qualifies it with !stall.
- upd_pc  in  32  PC of the resolved instruction.
- upd_is_cond  in  1  1 = beq/bne; 0 = j/jal/jr (unconditional).
- upd_taken  in  1  actual outcome (always 1 for unconditional).
- upd_target  in  32  actual target (branch target, jump target, or rs value for jr).
- upd_pred_taken  in  1  pred_taken originally issued for this instruction, carried down the pipe.
- upd_pred_target  in  32  pred_target originally issued for this instruction.
- mispredict  out  1  the update disagrees with the earlier prediction; the CPU flushes IF/ID.
- redirect_pc  out  32  correct next PC when mispredict is 1.
- branch_count  out  32  number of accepted updates.
- mispredict_count  out  32  number of mispredicts.

Behaviour:
- Indexing: idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2].
- Each entry holds valid, tag, target[31:0], uncond bit, and ctr[1:0].
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && (uncond || ctr[1]).
  - pred_target = pred_taken ? target : fetch_pc+4 (32-bit wrap).
- mispredict (combinational) = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Update on a rising edge with upd_valid=1 and rst=0, when the entry at upd idx hits:
  - Conditional: ctr increments on taken and decrements on not-taken, saturating at 3 and 0.
  - If taken, target <= upd_target.
  - uncond <= !upd_is_cond.
- Update when the entry misses:
  - upd_taken=1: allocate and overwrite any aliasing entry; valid=1, tag, target=upd_target, uncond=!upd_is_cond, ctr=2'b10.
  - upd_taken=0: no allocation, no table change.
- Statistics:
  - branch_count +1 per accepted update.
  - mispredict_count +1 when mispredict=1.
  - Both wrap modulo 2^32.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents; the new contents are visible the next cycle.
- Reset (synchronous, can occur mid-run):
  - Clears all valid bits and sets every ctr to CTR_INIT; targets and tags are don't-care.
  - Clears both statistics counters.
  - Any update presented in the reset cycle is ignored.
  - After reset, pred_taken=0 and pred_target=fetch_pc+4 for every fetch_pc.
  - The mispredict and redirect_pc outputs remain purely combinational during reset.
- No internal stall handling: the CPU holds fetch_pc and gates upd_valid while stalled.

Test Plan:
- After reset, fetch_pc=0x10: pred_taken=0, pred_target=0x14; both statistics counters are 0.
- Update upd_pc=0x10, cond, taken, target 0x40, pred_taken=0:
  - Same cycle: mispredict=1, redirect_pc=0x40.
  - Next cycle, fetch_pc=0x10: pred_taken=1, pred_target=0x40.
  - branch_count=1, mispredict_count=1.
- Two not-taken updates at 0x10 (first with upd_pred_taken=1, second with 0):
  - ctr goes 2→1→0.
  - First update: mispredict=1, redirect_pc=0x14. Second update: mispredict=0.
  - Lookup of 0x10 then gives pred_taken=0.
  - A further not-taken update keeps ctr at 0 (saturation).
- Alias and unconditional entries:
  - With 0x10 valid, lookup fetch_pc=0x50 (idx 4, tag 1): miss, pred_target=0x54.
  - Taken jr update at 0x50 with target 0x200 replaces the entry; 0x10 now misses.
  - A later jr update at 0x50 with target 0x300 and pred_target 0x200: mispredict=1, and the next lookup gives 0x300.
- Same-cycle hazard and reset:
  - Lookup 0x10 in the same cycle as its first taken update returns not-taken; the following cycle returns taken.
  - Asserting rst for one cycle mid-run clears the table and counters, and an update in that cycle has no effect.
